// File: rtl/glitch_stim_seq.sv
// glitch_stim_seq
// ---------------
// Stimulus sequencer for a combinational glitch detector. For each requested
// transition it drives the start vector for HOLD_CYC cycles, samples F, drives
// the end vector for HOLD_CYC cycles while counting F edges, samples F again
// and reports a static hazard when F ends where it began but moved in between.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start                   request a test (only honoured when idle)
//   from_vec, to_vec        start / end vectors {a,b,c,d}
//   f_in                    F output of the device under test (same domain)
//   a, b, c, d              registered drives to the device under test
//   busy                    test in progress
//   done                    one-cycle pulse, results valid in this cycle
//   hazard                  static-hazard flag, updated with done
//   f_from, f_to            F sampled at the end of the FROM / TO windows
//   edge_cnt                F changes seen during the TO window (saturating)
module glitch_stim_seq #(
    parameter int HOLD_CYC = 4,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    from_vec,
    input  logic [3:0]    to_vec,
    input  logic          f_in,
    output logic          a,
    output logic          b,
    output logic          c,
    output logic          d,
    output logic          busy,
    output logic          done,
    output logic          hazard,
    output logic          f_from,
    output logic          f_to,
    output logic [CW-1:0] edge_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FROM = 2'd1;
    localparam logic [1:0] ST_TO   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0]    HOLD_LAST = 8'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    logic [1:0]    state_q,  state_d;
    logic [7:0]    hold_q,   hold_d;
    logic [3:0]    to_q,     to_d;
    logic [3:0]    abcd_q,   abcd_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic          hazard_q, hazard_d;
    logic          f_from_q, f_from_d;
    logic          f_to_q,   f_to_d;
    logic          f_prev_q, f_prev_d;
    logic [CW-1:0] edge_q,   edge_d;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        to_d     = to_q;
        abcd_d   = abcd_q;
        busy_d   = busy_q;
        done_d   = done_q;
        hazard_d = hazard_q;
        f_from_d = f_from_q;
        f_to_d   = f_to_q;
        f_prev_d = f_prev_q;
        edge_d   = edge_q;

        case (state_q)
            ST_IDLE: begin
                // The start vector goes straight to the drive register; only
                // the end vector needs to be remembered.
                if (start) begin
                    to_d    = to_vec;
                    abcd_d  = from_vec;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_LAST;
                    state_d = ST_FROM;
                end
            end
            ST_FROM: begin
                if (hold_q == 8'd0) begin
                    f_from_d = f_in;
                    f_prev_d = f_in;
                    edge_d   = '0;
                    abcd_d   = to_q;
                    hold_d   = HOLD_LAST;
                    state_d  = ST_TO;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            ST_TO: begin
                if (f_in != f_prev_q && edge_q != CNT_MAX)
                    edge_d = edge_q + 1'b1;
                f_prev_d = f_in;
                if (hold_q == 8'd0) begin
                    f_to_d  = f_in;
                    state_d = ST_DONE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                // First DONE cycle registers the verdict and raises done; the
                // second (the visible done cycle) releases busy. start is not
                // looked at in either, so a request coinciding with done is
                // dropped and the next idle cycle accepts a new test.
                if (!done_q) begin
                    done_d   = 1'b1;
                    hazard_d = (f_from_q == f_to_q) && (edge_q != '0);
                end else begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            to_q     <= '0;
            abcd_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hazard_q <= 1'b0;
            f_from_q <= 1'b0;
            f_to_q   <= 1'b0;
            f_prev_q <= 1'b0;
            edge_q   <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
            abcd_q   <= abcd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hazard_q <= hazard_d;
            f_from_q <= f_from_d;
            f_to_q   <= f_to_d;
            f_prev_q <= f_prev_d;
            edge_q   <= edge_d;
        end
    end

    assign {a, b, c, d} = abcd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign hazard       = hazard_q;
    assign f_from       = f_from_q;
    assign f_to         = f_to_q;
    assign edge_cnt     = edge_q;

endmodule
